// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader:
// FSM encoding, default geometry and the base address of the image.
package imem_loader_pkg;

    localparam int          DEPTH_DEFAULT = 1024;
    localparam int          CNT_W_DEFAULT = 11;
    localparam logic [31:0] BOOT_BASE     = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    // Byte address of a word index; the result is always word-aligned.
    function automatic logic [31:0] word_addr(input logic [31:0] idx);
        return BOOT_BASE + {idx[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles a byte stream little-endian into 32-bit words. word/word_valid
// are combinational so the consumer can register the word on the same edge
// that accepts its last byte.
module imem_loader_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        take,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  cnt;
    logic [23:0] low;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= 2'd0;
            low <= 24'd0;
        end else if (take) begin
            cnt <= cnt + 2'd1;
            case (cnt)
                2'd0:    low[7:0]   <= data;
                2'd1:    low[15:8]  <= data;
                2'd2:    low[23:16] <= data;
                default: low        <= low;
            endcase
        end
    end

    // The fourth byte is never stored; it is spliced in directly.
    assign word       = {data, low};
    assign word_valid = take && (cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams a payload into instruction memory one word per write,
// then verifies an XOR checksum before releasing the core from reset.
//
// Handshake: a byte transfers on a rising edge where byte_valid and
// byte_ready are both 1; byte_ready depends only on state (LOAD or CHECK),
// and byte_valid may drop at any time without losing partial-word progress.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len_words,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wd,
    output logic             core_hold,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       dbg_state
);

    localparam logic [CNT_W-1:0] DEPTH_W = CNT_W'(DEPTH);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] len_r;
    logic [CNT_W-1:0] word_idx;
    logic [31:0]      acc;
    logic             start_ok;
    logic             take;
    logic [31:0]      word;
    logic             word_valid;

    imem_loader_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_ok),
        .take       (take),
        .data       (byte_data),
        .word       (word),
        .word_valid (word_valid)
    );

    assign start_ok = start && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign take     = byte_valid && byte_ready;

    always_comb begin
        state_n    = state;
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        core_hold  = 1'b1;
        case (state)
            LOAD: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (word_valid && ((word_idx + CNT_W'(1)) == len_r))
                    state_n = CHECK;
            end
            CHECK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (word_valid)
                    state_n = (word == acc) ? DONE : ERR;
            end
            default: begin
                // IDLE, DONE and ERR share the same entry rules.
                if (state == DONE) begin
                    done      = 1'b1;
                    core_hold = 1'b0;
                end
                if (state == ERR)
                    err = 1'b1;
                if (start_ok) begin
                    if (len_words > DEPTH_W)
                        state_n = ERR;
                    else if (len_words == '0)
                        state_n = CHECK;
                    else
                        state_n = LOAD;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            len_r    <= '0;
            word_idx <= '0;
            acc      <= 32'd0;
            mem_we   <= 1'b0;
            mem_addr <= 32'd0;
            mem_wd   <= 32'd0;
        end else begin
            state  <= state_n;
            mem_we <= 1'b0;
            if (start_ok) begin
                len_r    <= len_words;
                word_idx <= '0;
                acc      <= 32'd0;
            end else if ((state == LOAD) && word_valid) begin
                mem_we   <= 1'b1;
                mem_addr <= word_addr(32'(word_idx));
                mem_wd   <= word;
                word_idx <= word_idx + CNT_W'(1);
                acc      <= acc ^ word;
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: each scenario task drives a load and checks
// the captured memory writes and status flags against hand-computed values.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [10:0] len_words;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];

    logic [7:0] pay[8]   = '{8'h03, 8'hA3, 8'hC4, 8'hFF, 8'h83, 8'h23, 8'h83, 8'h00};
    logic [7:0] csum[4]  = '{8'h80, 8'h80, 8'h47, 8'hFF};
    int         gaps[12] = '{0, 3, 5, 1, 0, 2, 4, 0, 5, 1, 3, 0};

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len_words  (len_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .core_hold  (core_hold),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // write monitor
    always @(negedge clk) begin
        if (mem_we) got_q.push_back({mem_addr, mem_wd});
    end

    // driver tasks
    task automatic do_start(input logic [10:0] len);
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b1;
        len_words  = len;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            total++;
            bad++;
            $display("FAIL send_byte_timeout: byte_ready=%0b required=1", byte_ready);
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
    endtask

    task automatic send_good_image(input int use_gaps);
        for (int i = 0; i < 8; i++) send_byte(pay[i], use_gaps ? gaps[i] : 0);
        for (int i = 0; i < 4; i++) send_byte(csum[i], use_gaps ? gaps[8+i] : 0);
        idle_cycles(1);
    endtask

    // scenarios
    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (core_hold !== 1'b1) begin bad++; $display("FAIL reset_core_hold: got=%0b exp=1", core_hold); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we: got=%0b exp=0", mem_we); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%0b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got=%0b exp=0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got=%0b exp=0", err); end
        total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL reset_byte_ready: got=%0b exp=0", byte_ready); end
        total++; if ({mem_addr, mem_wd} !== 64'd0) begin bad++; $display("FAIL reset_addr_wd: got=%h exp=0", {mem_addr, mem_wd}); end
        total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state: got=%0d exp=0", dbg_state); end
        rst = 1'b0;
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = 8'hEE;
        @(negedge clk);
        byte_valid = 1'b0;
        total++; if (got_q.size() !== 0 || dbg_state !== 3'd0) begin bad++; $display("FAIL idle_byte_ignored: writes=%0d state=%0d exp=0/0", got_q.size(), dbg_state); end
    endtask

    task automatic test_load_ok;
        got_q.delete();
        exp_q.delete();
        exp_q.push_back({32'h0, 32'hFFC4A303});
        exp_q.push_back({32'h4, 32'h00832383});
        do_start(11'd2);
        total++; if (busy !== 1'b1 || core_hold !== 1'b1) begin bad++; $display("FAIL load_busy: busy=%0b hold=%0b exp=1/1", busy, core_hold); end
        send_good_image(0);
        total++; if (got_q.size() !== 2) begin bad++; $display("FAIL load_count: got=%0d exp=2", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL load_write%0d: got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        total++; if (done !== 1'b1 || core_hold !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL load_done: done=%0b hold=%0b busy=%0b exp=1/0/0", done, core_hold, busy); end
    endtask

    task automatic test_bad_checksum;
        got_q.delete();
        do_start(11'd2);
        for (int i = 0; i < 8; i++) send_byte(pay[i], 0);
        for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
        idle_cycles(1);
        total++; if (got_q.size() !== 2) begin bad++; $display("FAIL badsum_count: got=%0d exp=2", got_q.size()); end
        total++; if (err !== 1'b1 || core_hold !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL badsum_err: err=%0b hold=%0b done=%0b exp=1/1/0", err, core_hold, done); end
        got_q.delete();
        do_start(11'd2);
        total++; if (err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL retry_clear_err: err=%0b busy=%0b exp=0/1", err, busy); end
        send_good_image(0);
        total++; if (got_q.size() !== 2) begin bad++; $display("FAIL retry_count: got=%0d exp=2", got_q.size()); end
        total++; if (done !== 1'b1 || core_hold !== 1'b0) begin bad++; $display("FAIL retry_done: done=%0b hold=%0b exp=1/0", done, core_hold); end
    endtask

    task automatic test_len_bounds;
        got_q.delete();
        do_start(11'd1025);
        total++; if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL too_long_err: err=%0b busy=%0b done=%0b exp=1/0/0", err, busy, done); end
        total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL err_byte_ready: got=%0b exp=0", byte_ready); end
        idle_cycles(3);
        total++; if (got_q.size() !== 0) begin bad++; $display("FAIL too_long_writes: got=%0d exp=0", got_q.size()); end
        do_start(11'd0);
        total++; if (dbg_state !== 3'd2) begin bad++; $display("FAIL zero_len_check: state=%0d exp=2", dbg_state); end
        for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
        idle_cycles(1);
        total++; if (done !== 1'b1 || core_hold !== 1'b0 || got_q.size() !== 0) begin bad++; $display("FAIL zero_len_done: done=%0b hold=%0b writes=%0d exp=1/0/0", done, core_hold, got_q.size()); end
    endtask

    task automatic test_full_depth;
        logic [31:0] w;
        logic [31:0] x;
        int          mism;
        got_q.delete();
        x = 32'd0;
        do_start(11'd1024);
        total++; if (busy !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL full_accept: busy=%0b err=%0b exp=1/0", busy, err); end
        for (int i = 0; i < 1024; i++) begin
            w = {8'hC3, 8'h5A, 8'(i >> 8), 8'(i)};
            x = x ^ w;
            for (int k = 0; k < 4; k++) send_byte(w[k*8 +: 8], 0);
        end
        for (int k = 0; k < 4; k++) send_byte(x[k*8 +: 8], 0);
        idle_cycles(1);
        total++; if (got_q.size() !== 1024) begin bad++; $display("FAIL full_count: got=%0d exp=1024", got_q.size()); end
        mism = 0;
        for (int i = 0; i < got_q.size() && i < 1024; i++) begin
            w = {8'hC3, 8'h5A, 8'(i >> 8), 8'(i)};
            if (got_q[i] !== {32'(i) << 2, w}) mism++;
        end
        total++; if (mism !== 0) begin bad++; $display("FAIL full_writes: mismatched=%0d exp=0", mism); end
        if (got_q.size() > 0) begin
            total++; if (got_q[got_q.size()-1][63:32] !== 32'hFFC) begin bad++; $display("FAIL full_last_addr: got=%h exp=00000ffc", got_q[got_q.size()-1][63:32]); end
        end
        total++; if (done !== 1'b1 || core_hold !== 1'b0) begin bad++; $display("FAIL full_done: done=%0b hold=%0b exp=1/0", done, core_hold); end
    endtask

    task automatic test_stalls;
        got_q.delete();
        do_start(11'd2);
        for (int i = 0; i < 8; i++) begin
            send_byte(pay[i], gaps[i]);
            if (i == 2 || i == 5) begin
                @(negedge clk);
                byte_valid = 1'b0;
                start      = 1'b1;
                len_words  = 11'd5;
                @(negedge clk);
                start      = 1'b0;
                len_words  = 11'd2;
            end
        end
        for (int i = 0; i < 4; i++) send_byte(csum[i], gaps[8+i]);
        idle_cycles(1);
        total++; if (got_q.size() !== 2) begin bad++; $display("FAIL stall_count: got=%0d exp=2", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL stall_write%0d: got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        total++; if (done !== 1'b1 || core_hold !== 1'b0) begin bad++; $display("FAIL stall_done: done=%0b hold=%0b exp=1/0", done, core_hold); end
    endtask

    task automatic test_reset_abort;
        got_q.delete();
        do_start(11'd2);
        for (int i = 0; i < 5; i++) send_byte(pay[i], 0);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = pay[5];
        rst        = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        total++; if (dbg_state !== 3'd0 || busy !== 1'b0 || core_hold !== 1'b1) begin bad++; $display("FAIL abort_idle: state=%0d busy=%0b hold=%0b exp=0/0/1", dbg_state, busy, core_hold); end
        idle_cycles(4);
        total++; if (got_q.size() !== 1) begin bad++; $display("FAIL abort_writes: got=%0d exp=1", got_q.size()); end
        got_q.delete();
        do_start(11'd2);
        send_good_image(0);
        total++; if (got_q.size() !== 2) begin bad++; $display("FAIL reload_count: got=%0d exp=2", got_q.size()); end
        if (got_q.size() > 0) begin
            total++; if (got_q[0] !== exp_q[0]) begin bad++; $display("FAIL reload_first: got=%h exp=%h", got_q[0], exp_q[0]); end
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL reload_done: got=%0b exp=1", done); end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        len_words  = 11'd0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        test_reset();
        test_load_ok();
        test_bad_checksum();
        test_len_bounds();
        test_full_depth();
        test_stalls();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory. The memory is word-organised and indexed by byte address bits [31:2].
- Accepts a byte stream over a valid/ready handshake and assembles the bytes little-endian into 32-bit words.
- Issues one write per word to the memory's write port, starting at byte address 0, then checks an XOR checksum.
- Holds the core in reset (core_hold) from the start of a load until the load completes successfully.

Parameters:
- DEPTH, 1024: number of 32-bit words in the instruction memory.
- CNT_W, 11: width of the word-count input. Must satisfy 2**CNT_W > DEPTH.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE, DONE or ERR.
- len_words  input  CNT_W  number of payload words; sampled in the cycle start is accepted.
- byte_valid  input  1  byte_data is valid.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  write strobe to the instruction memory (one cycle per word).
- mem_addr  output  32  byte address of the write; always word-aligned (bits [1:0] = 0).
- mem_wd  output  32  write data.
- core_hold  output  1  high keeps the core in reset.
- busy  output  1  high in LOAD and CHECK.
- done  output  1  high in DONE; sticky until the next start or rst.
- err  output  1  high in ERR; sticky until the next start or rst.

Behaviour:
- Reset values (rst high at a clock edge), for all outputs:
  - state = IDLE.
  - byte_ready = 0, mem_we = 0, mem_addr = 0, mem_wd = 0.
  - busy = 0, done = 0, err = 0.
  - core_hold = 1. The core never runs unverified code after reset.
  - Internal state cleared: byte counter, word counter, word shift register, checksum accumulator.
- rst during LOAD or CHECK aborts the load immediately. Words already written remain in memory; no further writes are issued.
- Handshake: a byte transfers on a clock edge where byte_valid and byte_ready are both 1. byte_ready = 1 exactly in LOAD and CHECK.
- Byte assembly: a 2-bit byte counter selects the lane. Byte 0 goes to bits [7:0] and byte 3 to bits [31:24] (little-endian). The counter wraps 3 -> 0.
- Write timing:
  - On the edge that accepts byte 3 of a payload word, register mem_we = 1, mem_wd = the assembled word, and mem_addr = word_index << 2.
  - The write is therefore visible for exactly one cycle, one cycle after the handshake of byte 3.
  - word_index increments after the write, and the checksum accumulator XORs in the word.
- State machine:
  - IDLE: core_hold = 1.
    - start with len_words > DEPTH -> ERR.
    - start with len_words = 0 -> CHECK.
    - Any other start -> LOAD.
    - On entering LOAD, clear the counters and the accumulator.
  - LOAD: accept payload bytes. After byte 3 of word len_words-1 is accepted -> CHECK (same edge).
  - CHECK: accept 4 checksum bytes, assembled the same way. No mem_we is issued.
    - On byte 3: if the checksum equals the accumulator -> DONE, else -> ERR.
  - DONE: core_hold = 0, done = 1. start re-enters the load path, with the same rules as IDLE.
  - ERR: core_hold = 1, err = 1. start retries, with the same rules as IDLE.
- start asserted in LOAD or CHECK is ignored.
- Stalls: byte_valid may drop at any time. Partial-word state is kept indefinitely; there is no timeout.
- The last valid word address is (DEPTH-1) << 2. The word counter never wraps, because len_words > DEPTH is rejected up front.
- byte_valid asserted in IDLE, DONE or ERR: the byte is not accepted and has no effect.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE = 0, LOAD = 1, CHECK = 2, DONE = 3, ERR = 4 (3 bits);
  - DEPTH default;
  - BOOT_BASE = 32'h0000_0000.
- One natural sub-module: byte_packer (byte counter, shift register, word_valid pulse). It is reused for both payload and checksum words.
- The FSM, address counter and checksum accumulator live in imem_loader.

Test Plan:
1. Reset with rst = 1 for 2 cycles -> core_hold = 1; mem_we, busy, done, err and byte_ready all 0.
2. start with len_words = 2; stream bytes 03 A3 C4 FF 83 23 83 00, then checksum bytes 80 80 47 FF -> two writes:
   - addr 0x0, data 0xFFC4A303;
   - addr 0x4, data 0x00832383;
   - then done = 1 and core_hold = 0.
3. Same as scenario 2 but checksum bytes 00 00 00 00 -> exactly two writes, then err = 1 and core_hold stays 1. A following start retries successfully.
4. start with len_words = 1025 -> ERR on the next edge with zero mem_we pulses. start with len_words = 0 and checksum 00 00 00 00 -> DONE.
5. Stream with byte_valid gaps of 0 to 5 cycles, and start pulses during LOAD -> identical write sequence to scenario 2; the stray starts have no effect.
6. rst asserted after 5 payload bytes -> IDLE next cycle with no further writes. A fresh start then loads from addr 0x0.
